// File: rtl/general_pkg.sv
// General-purpose machine types shared across the interpreter datapath.
package general;

  localparam int ADDR_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/lisp_pkg.sv
// Lisp heap types: tagged cells, packed cons words, heap markers and the
// allocator state encoding.
package lisp;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 28;
  localparam int CELL_W = TAG_W + DATA_W;
  localparam int CONS_W = 2 * CELL_W;

  typedef enum logic [TAG_W-1:0] {
    Type_NIL    = 4'h0,
    Type_Number = 4'h1,
    Type_Symbol = 4'h2,
    Type_Cons   = 4'h3
  } type_t;

  typedef struct packed {
    type_t               tag;
    logic [DATA_W-1:0]   data;
  } cell_t;

  // car sits in the high half of the heap word.
  typedef struct packed {
    cell_t car;
    cell_t cdr;
  } cons_t;

  // Heap word markers. Tag 0xF is never produced for a real cell, so neither
  // marker can collide with a stored cons.
  localparam logic [CONS_W-1:0] MEM_FREE = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [CONS_W-1:0] MEM_USED = 64'hFFFF_FFFF_FFFF_FFFE;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    READ  = 3'd2,
    CHECK = 3'd3,
    WRITE = 3'd4,
    RESP  = 3'd5
  } alloc_state_t;

endpackage

// File: rtl/cons_alloc_heap_ptr_wrap.sv
// Heap scan pointer with increment-and-wrap over [BASE, BASE+DEPTH-1] and a
// probe counter that flags the step which completes DEPTH advances.
module heap_ptr_wrap import general::*; #(
  parameter addr_t BASE  = '0,
  parameter int    DEPTH = 256,
  parameter int    CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ptr_adv,
  input  logic              cnt_clr,
  input  logic              cnt_inc,
  output logic [ADDR_W-1:0] ptr,
  output logic              cnt_last
);

  localparam logic [ADDR_W-1:0] LAST = BASE + ADDR_W'(DEPTH - 1);

  logic [CNT_W-1:0] cnt;

  // One more increment from here makes DEPTH.
  assign cnt_last = (cnt == CNT_W'(DEPTH - 1));

  // Pointer wraps from LAST back to BASE; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= BASE;
      cnt <= '0;
    end else begin
      if (ptr_adv) ptr <= (ptr == LAST) ? BASE : ptr + ADDR_W'(1);
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cons_alloc.sv
// Cons-cell allocator: sweeps the heap to MEM_FREE after reset, then for each
// (car, cdr) request finds a free word by next-fit scan, writes the cons and
// returns a Type_Cons pointer cell (or an OOM response after one full lap).
//
// Handshakes: req and rsp are valid/ready; a transfer happens on a rising
// edge where both valid and ready are high. rsp_valid, once raised, holds with
// rsp_cell/rsp_oom stable until that edge. req_ready is high only in IDLE and
// req_valid is ignored otherwise.
module cons_alloc import general::*, lisp::*; #(
  parameter addr_t HEAP_BASE  = '0,
  parameter int    HEAP_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CELL_W-1:0] req_car,
  input  logic [CELL_W-1:0] req_cdr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [CELL_W-1:0] rsp_cell,
  output logic              rsp_oom,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [CONS_W-1:0] mem_wdata,
  input  logic [CONS_W-1:0] mem_rdata,
  output logic              init_done,
  output logic [2:0]        dbg_state
);

  alloc_state_t      state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              cnt_last;
  logic              ptr_adv, cnt_clr, cnt_inc;
  logic              latch_req, cap_ok, cap_oom;
  logic [CELL_W-1:0] car_q, cdr_q, cell_q;
  logic              oom_q;

  // The counter is shared: write count during INIT, probe count during a scan.
  heap_ptr_wrap #(
    .BASE  (HEAP_BASE),
    .DEPTH (HEAP_DEPTH)
  ) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .ptr_adv  (ptr_adv),
    .cnt_clr  (cnt_clr),
    .cnt_inc  (cnt_inc),
    .ptr      (ptr),
    .cnt_last (cnt_last)
  );

  assign rsp_cell  = cell_q;
  assign rsp_oom   = oom_q;
  assign init_done = (state != INIT);
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  // Next-state and strobes. INIT outputs are gated by rst_n so nothing is
  // written while reset is held.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_addr  = ptr;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    ptr_adv   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    latch_req = 1'b0;
    cap_ok    = 1'b0;
    cap_oom   = 1'b0;
    case (state)
      INIT: begin
        if (rst_n) begin
          mem_wr    = 1'b1;
          mem_wdata = MEM_FREE;
          ptr_adv   = 1'b1;
          cnt_inc   = 1'b1;
          if (cnt_last) begin
            cnt_clr   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          latch_req = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        mem_rd    = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        if (mem_rdata == MEM_FREE) begin
          state_nxt = WRITE;
        end else begin
          ptr_adv = 1'b1;
          cnt_inc = 1'b1;
          if (cnt_last) begin
            cap_oom   = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = READ;
          end
        end
      end
      WRITE: begin
        mem_wr    = 1'b1;
        mem_wdata = {car_q, cdr_q};
        cap_ok    = 1'b1;
        ptr_adv   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Request payload and response capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      car_q  <= '0;
      cdr_q  <= '0;
      cell_q <= '0;
      oom_q  <= 1'b0;
    end else begin
      if (latch_req) begin
        car_q <= req_car;
        cdr_q <= req_cdr;
      end
      if (cap_ok) begin
        cell_q <= {Type_Cons, {(DATA_W - ADDR_W){1'b0}}, ptr};
        oom_q  <= 1'b0;
      end else if (cap_oom) begin
        cell_q <= '0;
        oom_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cons_alloc.sv
// Bench for cons_alloc on a 4-word heap at 0x10 with a 1-cycle-latency memory
// model and a collector port for freeing words while the allocator is idle.
module tb_cons_alloc;
  import general::*;
  import lisp::*;

  localparam logic [ADDR_W-1:0] BASE   = 16'h0010;
  localparam int                BASE_I = 16;
  localparam int                DEPTH  = 4;

  logic              clk, rst_n;
  logic              req_valid, req_ready;
  logic [CELL_W-1:0] req_car, req_cdr;
  logic              rsp_valid, rsp_ready;
  logic [CELL_W-1:0] rsp_cell;
  logic              rsp_oom;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd, mem_wr;
  logic [CONS_W-1:0] mem_wdata, mem_rdata;
  logic              init_done;
  logic [2:0]        dbg_state;

  int total = 0;
  int bad   = 0;
  int excl_viol  = 0;
  int range_viol = 0;
  logic [CELL_W:0] exp_q[$];  // {oom, cell}

  logic [CONS_W-1:0] mem [0:255];
  logic              col_wr;
  logic [7:0]        col_addr;
  logic [CONS_W-1:0] col_data;

  typedef struct {
    logic              pre_en;
    logic [7:0]        pre_addr;
    logic [CONS_W-1:0] pre_data;
    logic [CELL_W-1:0] car;
    logic [CELL_W-1:0] cdr;
    logic [CELL_W-1:0] exp_cell;
    logic              exp_oom;
    int                exp_lat;
    int                hold;
  } vec_t;

  vec_t vecs[8];

  cons_alloc #(
    .HEAP_BASE  (BASE),
    .HEAP_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_car   (req_car),
    .req_cdr   (req_cdr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_cell  (rsp_cell),
    .rsp_oom   (rsp_oom),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .init_done (init_done),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary (got timeout, required finish)");
    $fatal(1);
  end

  // Single-port memory: allocator writes, collector writes, 1-cycle reads.
  always @(posedge clk) begin
    if (mem_wr)      mem[mem_addr[7:0]] <= mem_wdata;
    else if (col_wr) mem[col_addr] <= col_data;
    if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];
  end

  // Strobe sanity over the whole run.
  always @(negedge clk) begin
    if (mem_rd && mem_wr) excl_viol++;
    if (mem_wr && (mem_addr < BASE || mem_addr > BASE + ADDR_W'(DEPTH - 1))) range_viol++;
  end

  function automatic logic [CELL_W-1:0] mk(input type_t t, input int v);
    return {t, DATA_W'(v)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reset, check quiet outputs, release, then follow the 4-word sweep.
  task automatic init_seq();
    rst_n = 1'b0;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      check("reset_ctrl", 64'({req_ready, rsp_valid, rsp_oom, mem_rd, mem_wr, init_done}), 64'd0);
      check("reset_cell", 64'(rsp_cell), 64'd0);
      check("reset_addr", 64'(mem_addr), 64'(BASE));
      check("reset_wdata", mem_wdata, 64'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("init_wr", 64'({mem_wr, mem_rd, init_done}), 64'b100);
      check("init_addr", 64'(mem_addr), 64'(BASE) + 64'(i));
      check("init_wdata", mem_wdata, MEM_FREE);
      @(negedge clk);
    end
    #1;
    check("init_done_ready", 64'({init_done, req_ready, mem_wr}), 64'b110);
    @(negedge clk);
  endtask

  task automatic collector_write(input logic [7:0] a, input logic [CONS_W-1:0] d);
    @(negedge clk);
    col_wr = 1'b1; col_addr = a; col_data = d;
    @(posedge clk);
    #1 col_wr = 1'b0;
  endtask

  // Drive one request, measure latency, optionally stall, then handshake.
  task automatic do_alloc(input vec_t v);
    int n;
    logic [CONS_W-1:0] snap [DEPTH];
    logic [CELL_W:0]   act, expv;
    for (int a = 0; a < DEPTH; a++) snap[a] = mem[BASE_I + a];
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_car = v.car; req_cdr = v.cdr;
    @(posedge clk);
    exp_q.push_back({v.exp_oom, v.exp_cell});
    #1 req_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!rsp_valid && n < 60) begin @(negedge clk); n++; end
    check("rsp_latency", 64'(n), 64'(v.exp_lat));
    for (int h = 0; h < v.hold; h++) begin
      req_valid = 1'b1; req_car = mk(Type_Symbol, 99);
      @(negedge clk);
      check("stall_valid", 64'(rsp_valid), 64'd1);
      check("stall_cell", 64'({rsp_oom, rsp_cell}), 64'({v.exp_oom, v.exp_cell}));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    act = {rsp_oom, rsp_cell};
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      check("rsp_cell_oom", 64'(act), 64'(expv));
    end else begin
      check("scoreboard_underflow", 64'd1, 64'd0);
    end
    @(negedge clk);
    check("idle_after_rsp", 64'({req_ready, rsp_valid}), 64'b10);
    if (v.exp_oom) begin
      for (int a = 0; a < DEPTH; a++) check("oom_mem_unchanged", mem[BASE_I + a], snap[a]);
    end else begin
      check("mem_cons", mem[v.exp_cell[7:0]], {v.car, v.cdr});
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_car = '0; req_cdr = '0; rsp_ready = 1'b0;
    col_wr = 1'b0; col_addr = '0; col_data = '0;

    // {pre_en, pre_addr, pre_data, car, cdr, exp_cell, exp_oom, exp_lat, hold}
    vecs[0] = '{1'b0, 8'h00, 64'h0, mk(Type_Number, 5), mk(Type_NIL, 0),
                mk(Type_Cons, 16'h10), 1'b0, 4, 3};
    vecs[1] = '{1'b0, 8'h00, 64'h0, mk(Type_Number, 7), mk(Type_Cons, 16'h10),
                mk(Type_Cons, 16'h11), 1'b0, 4, 0};
    vecs[2] = '{1'b0, 8'h00, 64'h0, mk(Type_Symbol, 3), mk(Type_Cons, 16'h11),
                mk(Type_Cons, 16'h12), 1'b0, 4, 0};
    vecs[3] = '{1'b0, 8'h00, 64'h0, mk(Type_Number, 9), mk(Type_NIL, 0),
                mk(Type_Cons, 16'h13), 1'b0, 4, 1};
    vecs[4] = '{1'b0, 8'h00, 64'h0, mk(Type_Number, 11), mk(Type_NIL, 0),
                32'h0, 1'b1, 9, 0};
    // Near-miss of MEM_FREE is still occupied.
    vecs[5] = '{1'b1, 8'h13, MEM_FREE ^ 64'h1, mk(Type_Number, 12), mk(Type_NIL, 0),
                32'h0, 1'b1, 9, 2};
    // Scan starts at 0x10 (used), finds freed 0x11.
    vecs[6] = '{1'b1, 8'h11, MEM_FREE, mk(Type_Number, 13), mk(Type_Cons, 16'h10),
                mk(Type_Cons, 16'h11), 1'b0, 6, 0};
    // Scan 0x12, 0x13, wraps to freed 0x10.
    vecs[7] = '{1'b1, 8'h10, MEM_FREE, mk(Type_Number, 14), mk(Type_NIL, 0),
                mk(Type_Cons, 16'h10), 1'b0, 8, 0};

    init_seq();

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre_en) collector_write(vecs[i].pre_addr, vecs[i].pre_data);
      do_alloc(vecs[i]);
    end

    // Reset while in CHECK: request is dropped, heap re-swept.
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_car = mk(Type_Number, 1); req_cdr = mk(Type_NIL, 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("state_before_reset", 64'(dbg_state), 64'(CHECK));
    init_seq();
    check("no_rsp_after_reset", 64'(rsp_valid), 64'd0);
    do_alloc('{1'b0, 8'h00, 64'h0, mk(Type_Number, 21), mk(Type_NIL, 0),
               mk(Type_Cons, 16'h10), 1'b0, 4, 0});

    check("rd_wr_exclusive", 64'(excl_viol), 64'd0);
    check("wr_in_heap", 64'(range_viol), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
